// File: rtl/demux7_collector_if.sv
// Bit-collector bus: tagged-bit input side plus the assembled-word output side.
interface demux7_collector_if #(
    parameter int unsigned NSLOTS = 7,
    parameter int unsigned SEL_W  = 3
);
    logic              bit_in;
    logic [SEL_W-1:0]  select_bus;
    logic              bit_valid;
    logic              bit_ready;
    logic [NSLOTS-1:0] data_bus;
    logic              data_valid;
    logic              data_ready;
    logic [NSLOTS-1:0] filled_mask;
    logic [SEL_W-1:0]  fill_count;
    logic              sel_error;
    logic              dup_error;

    // Producer/consumer side (drives bits in, accepts the word)
    modport master (
        output bit_in, select_bus, bit_valid, data_ready,
        input  bit_ready, data_bus, data_valid, filled_mask, fill_count, sel_error, dup_error
    );

    // Collector side
    modport slave (
        input  bit_in, select_bus, bit_valid, data_ready,
        output bit_ready, data_bus, data_valid, filled_mask, fill_count, sel_error, dup_error
    );
endinterface

// File: rtl/demux7_collector.sv
// Collects slot-tagged bits into a 7-bit word and hands the word off on a
// valid/ready handshake once every slot has been written since the last drain.
module demux7_collector #(
    parameter int unsigned NSLOTS = 7,
    parameter int unsigned SEL_W  = 3
) (
    input logic                clock,
    input logic                resetn,
    demux7_collector_if.slave  bus_io
);

    typedef enum logic [1:0] {
        StInit    = 2'd0,
        StCollect = 2'd1,
        StHold    = 2'd2
    } state_e;

    state_e            state_q;
    logic              bit_ready_q;
    logic [NSLOTS-1:0] data_q;
    logic              data_valid_q;
    logic [NSLOTS-1:0] filled_q;
    logic [SEL_W-1:0]  count_q;
    logic              sel_error_q;
    logic              dup_error_q;

    logic [NSLOTS-1:0] slot_oh;
    logic              sel_ok;
    logic              is_dup;
    logic              completes;

    // Decode the slot index exhaustively; code 7 (and any unknown) selects nothing.
    always_comb begin
        slot_oh = '0;
        sel_ok  = 1'b0;
        case (bus_io.select_bus)
            3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6: begin
                sel_ok  = 1'b1;
                slot_oh = {{(NSLOTS-1){1'b0}}, 1'b1} << bus_io.select_bus;
            end
            default: begin
                sel_ok  = 1'b0;
                slot_oh = '0;
            end
        endcase
        is_dup    = |(filled_q & slot_oh);
        completes = &(filled_q | slot_oh);
    end

    // Control FSM with all outputs registered alongside the state.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StInit;
            bit_ready_q  <= 1'b0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            filled_q     <= '0;
            count_q      <= '0;
            sel_error_q  <= 1'b0;
            dup_error_q  <= 1'b0;
        end else begin
            sel_error_q <= 1'b0;
            dup_error_q <= 1'b0;
            case (state_q)
                StInit: begin
                    state_q     <= StCollect;
                    bit_ready_q <= 1'b1;
                end
                StCollect: begin
                    if (bus_io.bit_valid && bit_ready_q) begin
                        if (!sel_ok) begin
                            sel_error_q <= 1'b1;
                        end else begin
                            data_q   <= (data_q & ~slot_oh) | (bus_io.bit_in ? slot_oh : '0);
                            filled_q <= filled_q | slot_oh;
                            if (is_dup) begin
                                dup_error_q <= 1'b1;
                            end else begin
                                count_q <= count_q + 3'd1;
                                // Last distinct slot: present the word on the next cycle
                                if (completes) begin
                                    state_q      <= StHold;
                                    data_valid_q <= 1'b1;
                                    bit_ready_q  <= 1'b0;
                                end
                            end
                        end
                    end
                end
                StHold: begin
                    // Drain costs one cycle; no bit can be taken on this edge
                    if (bus_io.data_ready) begin
                        state_q      <= StCollect;
                        data_valid_q <= 1'b0;
                        bit_ready_q  <= 1'b1;
                        data_q       <= '0;
                        filled_q     <= '0;
                        count_q      <= '0;
                    end
                end
                default: begin
                    state_q      <= StInit;
                    bit_ready_q  <= 1'b0;
                    data_q       <= '0;
                    data_valid_q <= 1'b0;
                    filled_q     <= '0;
                    count_q      <= '0;
                end
            endcase
        end
    end

    assign bus_io.bit_ready   = bit_ready_q;
    assign bus_io.data_bus    = data_q;
    assign bus_io.data_valid  = data_valid_q;
    assign bus_io.filled_mask = filled_q;
    assign bus_io.fill_count  = count_q;
    assign bus_io.sel_error   = sel_error_q;
    assign bus_io.dup_error   = dup_error_q;

endmodule
